// File: rtl/param_shift_sequencer.sv
// Multi-cycle WIDTH-bit shifter: one bit position per clock, four shift modes,
// programmable count, start/busy/done handshake.
module param_shift_sequencer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             shift_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, amt_clamp;
    logic [1:0]       mode_q, mode_nxt;
    logic [WIDTH-1:0] q_nxt, sh_q;
    logic             so_nxt, sh_bit;

    assign amt_clamp = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

    // One-bit shift of the current contents under the latched mode.
    always_comb begin
        sh_q   = Q;
        sh_bit = Q[0];
        case (mode_q)
            2'b00: sh_q = {1'b0, Q[WIDTH-1:1]};
            2'b01: sh_q = {Q[WIDTH-1], Q[WIDTH-1:1]};
            2'b10: begin
                sh_q   = {Q[WIDTH-2:0], 1'b0};
                sh_bit = Q[WIDTH-1];
            end
            default: sh_q = {Q[0], Q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        q_nxt     = Q;
        so_nxt    = shift_out;
        if (!load_n) begin
            // A load in any state wins and abandons a sequence without a done pulse.
            q_nxt     = load_val;
            so_nxt    = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_nxt  = mode;
                    cnt_nxt   = amt_clamp;
                    state_nxt = (amt_clamp != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    q_nxt   = sh_q;
                    so_nxt  = sh_bit;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 2'b00;
            Q         <= '0;
            shift_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mode_q    <= mode_nxt;
            Q         <= q_nxt;
            shift_out <= so_nxt;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/param_shift_sequencer.md
# param_shift_sequencer

Parametrised multi-cycle shift unit. Generalises the team's 8-bit load/shift-right/ASR register to `WIDTH` bits, four shift modes and a programmable shift count. It shifts one bit position per clock under a start/busy/done handshake. It sits between switch/CPU-side stimulus and datapath consumers that need N-bit shifts without a combinational barrel shifter.

## Interface
- `WIDTH`, default 8: register width. Legal range is `WIDTH >= 2`.
- `CNT_W`, localparam = `$clog2(WIDTH+1)`: width of the shift-amount port. Not overridable.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_n`  in  1  synchronous parallel load, active low. Highest priority after reset.
- `load_val`  in  WIDTH  parallel load data.
- `start`  in  1  request a shift sequence. Sampled only in IDLE.
- `amount`  in  CNT_W  number of 1-bit shifts. Values above `WIDTH` clamp to `WIDTH`.
- `mode`  in  2  shift mode: 00 LSR (fill 0), 01 ASR (fill MSB), 10 LSL (fill 0), 11 ROR (fill Q[0]).
- `Q`  out  WIDTH  register contents.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `shift_out`  out  1  the bit that left the register on the most recent shift.

## Operation
- **Reset** (`reset_n`=0, asynchronous): `Q`=0, `shift_out`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `load_n`=0 → `Q`←`load_val`, `shift_out`←0, stay in IDLE. A `start` in the same cycle is ignored.
  - `start`=1 with `load_n`=1 → latch `mode`, latch clamped `amount` into the counter. Go to SHIFT if count>0, else go to DONE.
- **SHIFT:**
  - Each clock performs one 1-bit shift using the latched mode and decrements the counter.
  - When the counter reaches 0 on that edge, go to DONE.
  - `start` is ignored. Changes to `mode` or `amount` have no effect.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE unconditionally. `start` is ignored in DONE.
- **Load mid-operation:** `load_n`=0 in SHIFT or DONE loads `Q` and forces IDLE. No `done` pulse is produced and the counter is cleared.
- **Shift rules:**
  - LSR: `Q`←{0, Q[W-1:1]}, `shift_out`←Q[0].
  - ASR: `Q`←{Q[W-1], Q[W-1:1]}, `shift_out`←Q[0].
  - LSL: `Q`←{Q[W-2:0], 0}, `shift_out`←Q[W-1].
  - ROR: `Q`←{Q[0], Q[W-1:1]}, `shift_out`←Q[0].
- **Clamp boundary:** `amount`≥`WIDTH` gives the following results.
  - LSR/LSL: `Q`=0.
  - ASR: `Q` = all copies of the original MSB.
  - ROR: `Q` = original value.
- **Reset mid-sequence:** reset aborts immediately to the reset values, with no `done`.

## Timing
- `start` is accepted at edge E0. `busy`=1 from E0 through EN, where N is the clamped amount.
- Shifts occur at edges E1..EN. `Q` is valid after each edge.
- `done`=1 in the cycle after EN (state DONE) and `busy`=0 in that cycle. IDLE is reached after EN+1.
- Total latency from the start edge to the `done` pulse is N+1 cycles. For N=0, `done` is high in the cycle after E0.
- The earliest next accepted `start` is at edge EN+2.
- Outputs are fully registered: `busy` and `done` decode from the state register, with no combinational path from inputs.

## Test plan
- **Reset and load:** assert `reset_n`=0 mid-cycle → `Q`=0, `busy`=0, `done`=0 immediately. Release reset, then load `load_val`=8'hB4 → `Q`=8'hB4, `shift_out`=0.
- **ASR sign fill:** WIDTH=8, `Q`=8'hB4, mode=01, amount=3 → `busy` high for 3 cycles, `Q` sequence 8'hDA, 8'hED, 8'hF6. `shift_out` is 0, then 0, then 1. `done` pulses on cycle 4.
- **LSL and clamp:** `Q`=8'h81, mode=10, amount=3 → `Q`=8'h08, `shift_out`=0. Then load 8'hFF, mode=00, amount=15 (clamps to 8) → `Q`=8'h00 after 8 shifts and `done` at cycle 9.
- **Rotate full circle:** `Q`=8'h3C, mode=11, amount=8 → `Q`=8'h3C at done. Mid-sequence after 2 shifts `Q`=8'h0F.
- **Zero amount and ignored start:** amount=0 → no `Q` change, `busy` never high, `done` in the next cycle. Asserting `start` while busy leaves the counter unchanged and yields exactly one `done`.
- **Abort:** LSR amount=5; after 2 shifts drive `load_n`=0 with 8'h55 → `Q`=8'h55, state IDLE, no `done` pulse for the next 10 cycles. Then load and start together in IDLE → load wins and `busy` stays 0.
